stack_calc_core: RTL and testbench

Parametrised successor to the 4-bit stack calculator: a single-clock stack-machine execution core with configurable data width and stack depth. It adds a valid/ready opcode handshake, underflow/overflow detection with a sticky error flag, a carry flag, and an extended opcode set. It sits between the pin-level input decoder and the output multiplexer / seven-segment decoder. It exposes top-of-stack, second-of-stack and the output latch for display.

---
 rtl/stack_calc_core_pkg.sv | 38 +++
 rtl/stack_calc_core_if.sv | 12 +
 rtl/stack_calc_core_stack_file.sv | 77 +++++++
 rtl/stack_calc_core.sv | 128 ++++++++++++
 tb/tb_stack_calc_core.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_calc_core_pkg.sv
// Shared opcode, FSM state and stack-command encodings for the stack calculator core.
package stack_calc_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_PUSH = 4'h1,
    OP_POP  = 4'h2,
    OP_OUTL = 4'h3,
    OP_OUTH = 4'h4,
    OP_SWAP = 4'h5,
    OP_DUP  = 4'h6,
    OP_OVER = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_ADD  = 4'hA,
    OP_SUB  = 4'hB,
    OP_XOR  = 4'hC,
    OP_NOT  = 4'hD,
    OP_INC  = 4'hE,
    OP_CLR  = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SF_HOLD,
    SF_PUSH,
    SF_POP,
    SF_REPL,
    SF_POPREPL,
    SF_SWAP,
    SF_CLR
  } sf_cmd_e;

endpackage

// File: rtl/stack_calc_core_if.sv
// Opcode handshake between the input decoder (master) and the execution core (slave).
interface stack_calc_core_if #(
  parameter int WIDTH = 4
) ();
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand;

  modport master (output op_valid, output opcode, output operand, input op_ready);
  modport slave  (input op_valid, input opcode, input operand, output op_ready);
endinterface

// File: rtl/stack_calc_core_stack_file.sv
// Shift-register stack: entry 0 is always the top, so push/pop shift every entry one place.
module stack_file
  import stack_calc_core_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sf_cmd_e          cmd_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] top_o,
  output logic [WIDTH-1:0] second_o,
  output logic [DW-1:0]    depth_o
);

  logic [WIDTH-1:0] entry [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [WIDTH-1:0] ent_q, ent_d, above, below, swapped;

    if (gi == 0) begin : g_first
      assign above   = wdata_i;
      assign swapped = entry[1];
    end else begin : g_rest
      assign above   = entry[gi-1];
      assign swapped = (gi == 1) ? entry[0] : ent_q;
    end

    if (gi == DEPTH - 1) begin : g_last
      assign below = ent_q;
    end else begin : g_mid
      assign below = entry[gi+1];
    end

    always_comb begin
      ent_d = ent_q;
      case (cmd_i)
        SF_PUSH:    ent_d = above;
        SF_POP:     ent_d = below;
        SF_REPL:    ent_d = (gi == 0) ? wdata_i : ent_q;
        SF_POPREPL: ent_d = (gi == 0) ? wdata_i : below;
        SF_SWAP:    ent_d = swapped;
        default:    ent_d = ent_q;
      endcase
    end

    // Contents are don't-care after reset; validity is tracked by depth alone.
    always_ff @(posedge clk) begin
      ent_q <= ent_d;
    end

    assign entry[gi] = ent_q;
  end

  always_comb begin
    depth_d = depth_q;
    case (cmd_i)
      SF_PUSH:            depth_d = depth_q + DW'(1);
      SF_POP, SF_POPREPL: depth_d = depth_q - DW'(1);
      SF_CLR:             depth_d = '0;
      default:            depth_d = depth_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  assign depth_o  = depth_q;
  assign top_o    = (depth_q != '0) ? entry[0] : '0;
  assign second_o = (depth_q >= DW'(2)) ? entry[1] : '0;

endmodule

// File: rtl/stack_calc_core.sv
// Stack-machine execution core: IDLE/EXEC handshake FSM, ALU, flags and output latch.
module stack_calc_core
  import stack_calc_core_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  stack_calc_core_if.slave   bus,
  output logic [WIDTH-1:0]   top,
  output logic [WIDTH-1:0]   second,
  output logic [DW-1:0]      depth,
  output logic               empty,
  output logic               full,
  output logic               carry,
  output logic               error,
  output logic [2*WIDTH-1:0] out_reg
);

  state_e             state_q, state_d;
  opcode_e            op_q;
  logic [WIDTH-1:0]   arg_q;
  logic               carry_q, carry_d, error_q, error_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               op_ready, accept, lack1, lack2, at_full;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff, sf_wdata;
  sf_cmd_e            sf_cmd;

  stack_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_i    (sf_cmd),
    .wdata_i  (sf_wdata),
    .top_o    (top),
    .second_o (second),
    .depth_o  (depth)
  );

  assign accept = (state_q == ST_IDLE) && bus.op_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.op_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state_q == ST_IDLE);
    sf_cmd   = SF_HOLD;
    sf_wdata = '0;
    carry_d  = carry_q;
    error_d  = error_q;
    out_d    = out_q;
    sum      = {1'b0, second} + {1'b0, top};
    diff     = second - top;
    lack1    = (depth == '0);
    lack2    = (depth < DW'(2));
    at_full  = (depth == DW'(DEPTH));
    // A failed precondition only sets error; stack, carry and out_reg stay put.
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_PUSH: if (at_full) error_d = 1'b1;
                 else begin sf_cmd = SF_PUSH; sf_wdata = arg_q; end
        OP_POP:  if (lack1) error_d = 1'b1; else sf_cmd = SF_POP;
        OP_OUTL: if (lack1) error_d = 1'b1; else out_d[WIDTH-1:0] = top;
        OP_OUTH: if (lack1) error_d = 1'b1; else out_d[2*WIDTH-1:WIDTH] = top;
        OP_SWAP: if (lack2) error_d = 1'b1; else sf_cmd = SF_SWAP;
        OP_DUP:  if (lack1 || at_full) error_d = 1'b1;
                 else begin sf_cmd = SF_PUSH; sf_wdata = top; end
        OP_OVER: if (lack2 || at_full) error_d = 1'b1;
                 else begin sf_cmd = SF_PUSH; sf_wdata = second; end
        OP_AND:  if (lack2) error_d = 1'b1;
                 else begin sf_cmd = SF_POPREPL; sf_wdata = second & top; end
        OP_OR:   if (lack2) error_d = 1'b1;
                 else begin sf_cmd = SF_POPREPL; sf_wdata = second | top; end
        OP_ADD:  if (lack2) error_d = 1'b1;
                 else begin sf_cmd = SF_POPREPL; sf_wdata = sum[WIDTH-1:0]; carry_d = sum[WIDTH]; end
        OP_SUB:  if (lack2) error_d = 1'b1;
                 else begin sf_cmd = SF_POPREPL; sf_wdata = diff; carry_d = (second < top); end
        OP_XOR:  if (lack2) error_d = 1'b1;
                 else begin sf_cmd = SF_POPREPL; sf_wdata = second ^ top; end
        OP_NOT:  if (lack1) error_d = 1'b1;
                 else begin sf_cmd = SF_REPL; sf_wdata = ~top; end
        OP_INC:  if (lack1) error_d = 1'b1;
                 else begin sf_cmd = SF_REPL; sf_wdata = top + WIDTH'(1); end
        OP_CLR:  begin sf_cmd = SF_CLR; error_d = 1'b0; carry_d = 1'b0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NOP;
      arg_q   <= '0;
      carry_q <= 1'b0;
      error_q <= 1'b0;
      out_q   <= '0;
    end else begin
      if (accept) begin
        op_q  <= opcode_e'(bus.opcode);
        arg_q <= bus.operand;
      end
      carry_q <= carry_d;
      error_q <= error_d;
      out_q   <= out_d;
    end
  end

  assign bus.op_ready = op_ready;
  assign empty        = (depth == '0);
  assign full         = (depth == DW'(DEPTH));
  assign carry        = carry_q;
  assign error        = error_q;
  assign out_reg      = out_q;

endmodule

// File: tb/tb_stack_calc_core.sv
// Self-checking bench: directed scenarios with literal checks plus random ops against a list-style stack model.
module tb_stack_calc_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] top, second;
  logic [2:0] depth;
  logic       empty, full, carry, error;
  logic [7:0] out_reg;

  int n_cmp = 0;
  int n_bad = 0;

  stack_calc_core_if #(.WIDTH(4)) bus ();

  stack_calc_core #(.WIDTH(4), .DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .top     (top),
    .second  (second),
    .depth   (depth),
    .empty   (empty),
    .full    (full),
    .carry   (carry),
    .error   (error),
    .out_reg (out_reg)
  );

  initial forever #5 clk = ~clk;

  // Model stack is bottom-indexed: stk[0] is the oldest entry, stk[depth-1] the top.
  typedef struct packed {
    logic [2:0]      depth;
    logic [3:0][3:0] stk;
    logic            carry;
    logic            err;
    logic [7:0]      outv;
  } model_t;

  model_t     m_q;
  logic       m_busy;
  logic [3:0] pend_op, pend_val;

  function automatic logic [3:0] mtop(model_t m);
    return (m.depth >= 3'd1) ? m.stk[2'(m.depth - 3'd1)] : 4'h0;
  endfunction

  function automatic logic [3:0] msec(model_t m);
    return (m.depth >= 3'd2) ? m.stk[2'(m.depth - 3'd2)] : 4'h0;
  endfunction

  function automatic model_t step(model_t m, logic [3:0] op, logic [3:0] v);
    logic [3:0] t, s;
    int d, sm, df;
    bit need1, need2, grow;
    t = mtop(m);
    s = msec(m);
    d = int'(m.depth);
    need1 = op inside {4'h2, 4'h3, 4'h4, 4'h6, 4'hD, 4'hE};
    need2 = op inside {4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    grow  = op inside {4'h1, 4'h6, 4'h7};
    if (op == 4'hF) begin
      m.depth = 3'd0; m.err = 1'b0; m.carry = 1'b0;
      return m;
    end
    if ((need1 && d < 1) || (need2 && d < 2) || (grow && d == 4)) begin
      m.err = 1'b1;
      return m;
    end
    case (op)
      4'h1: begin m.stk[2'(d)] = v; m.depth = 3'(d + 1); end
      4'h6: begin m.stk[2'(d)] = t; m.depth = 3'(d + 1); end
      4'h7: begin m.stk[2'(d)] = s; m.depth = 3'(d + 1); end
      4'h2: m.depth = 3'(d - 1);
      4'h3: m.outv[3:0] = t;
      4'h4: m.outv[7:4] = t;
      4'h5: begin m.stk[2'(d - 1)] = s; m.stk[2'(d - 2)] = t; end
      4'h8: begin m.stk[2'(d - 2)] = s & t; m.depth = 3'(d - 1); end
      4'h9: begin m.stk[2'(d - 2)] = s | t; m.depth = 3'(d - 1); end
      4'hC: begin m.stk[2'(d - 2)] = s ^ t; m.depth = 3'(d - 1); end
      4'hA: begin
        sm = int'(s) + int'(t);
        m.stk[2'(d - 2)] = 4'(sm); m.depth = 3'(d - 1); m.carry = (sm > 15);
      end
      4'hB: begin
        df = int'(s) - int'(t);
        m.stk[2'(d - 2)] = 4'(df); m.depth = 3'(d - 1); m.carry = (df < 0);
      end
      4'hD: m.stk[2'(d - 1)] = ~t;
      4'hE: m.stk[2'(d - 1)] = 4'(int'(t) + 1);
      default: ;
    endcase
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      m_q    <= step(m_q, pend_op, pend_val);
      m_busy <= 1'b0;
    end else if (bus.op_valid) begin
      m_busy   <= 1'b1;
      pend_op  <= bus.opcode;
      pend_val <= bus.operand;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_ready",  32'(bus.op_ready), 32'(!m_busy));
    chk("m_depth",  32'(depth),   32'(m_q.depth));
    chk("m_top",    32'(top),     32'(mtop(m_q)));
    chk("m_second", 32'(second),  32'(msec(m_q)));
    chk("m_empty",  32'(empty),   32'(m_q.depth == 3'd0));
    chk("m_full",   32'(full),    32'(m_q.depth == 3'd4));
    chk("m_carry",  32'(carry),   32'(m_q.carry));
    chk("m_error",  32'(error),   32'(m_q.err));
    chk("m_out",    32'(out_reg), 32'(m_q.outv));
  end

  // Called at a falling edge; returns at the falling edge after the op's results land.
  task automatic run_op(input logic [3:0] op, input logic [3:0] val);
    int w;
    w = 0;
    bus.opcode   = op;
    bus.operand  = val;
    bus.op_valid = 1'b1;
    while (!bus.op_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!bus.op_ready) begin
      chk("ready_wait", 32'(bus.op_ready), 32'd1);
      bus.op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    @(negedge clk);
    chk("ready_low", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
  endtask

  logic [3:0] rop, rval;

  initial begin
    bus.op_valid = 1'b0;
    bus.opcode   = 4'h0;
    bus.operand  = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_out",   32'(out_reg), 32'd0);

    run_op(4'h1, 4'd3); run_op(4'h1, 4'd5); run_op(4'hA, 4'd0);
    chk("s1_top", 32'(top), 32'd8);
    chk("s1_depth", 32'(depth), 32'd1);
    chk("s1_carry", 32'(carry), 32'd0);
    chk("s1_error", 32'(error), 32'd0);

    run_op(4'h1, 4'd9); run_op(4'h1, 4'd9); run_op(4'hA, 4'd0);
    chk("s2_add_top", 32'(top), 32'd2);
    chk("s2_add_carry", 32'(carry), 32'd1);
    run_op(4'h1, 4'd5); run_op(4'hB, 4'd0);
    chk("s2_sub_top", 32'(top), 32'd13);
    chk("s2_sub_carry", 32'(carry), 32'd1);
    run_op(4'hF, 4'd0);

    for (int i = 1; i <= 4; i++) run_op(4'h1, 4'(i));
    chk("s3_full", 32'(full), 32'd1);
    run_op(4'h1, 4'd7);
    chk("s3_ovf_error", 32'(error), 32'd1);
    chk("s3_ovf_depth", 32'(depth), 32'd4);
    chk("s3_ovf_top", 32'(top), 32'd4);
    run_op(4'hF, 4'd0);
    chk("s3_clr_depth", 32'(depth), 32'd0);
    chk("s3_clr_empty", 32'(empty), 32'd1);
    chk("s3_clr_error", 32'(error), 32'd0);

    run_op(4'h2, 4'd0);
    chk("s4_unf_error", 32'(error), 32'd1);
    chk("s4_unf_depth", 32'(depth), 32'd0);
    chk("s4_unf_top", 32'(top), 32'd0);
    run_op(4'h1, 4'd6);
    chk("s4_push_top", 32'(top), 32'd6);
    chk("s4_sticky", 32'(error), 32'd1);
    run_op(4'hF, 4'd0);

    run_op(4'h1, 4'hA); run_op(4'h3, 4'd0); run_op(4'h1, 4'h5); run_op(4'h4, 4'd0);
    chk("s5_out", 32'(out_reg), 32'h5A);
    run_op(4'h5, 4'd0);
    chk("s5_swap_top", 32'(top), 32'hA);
    chk("s5_swap_second", 32'(second), 32'h5);
    run_op(4'hF, 4'd0);

    bus.opcode   = 4'h1;
    bus.operand  = 4'd1;
    bus.op_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("s6_ready_%0d", k), 32'(bus.op_ready), 32'(k % 2 == 0));
    end
    chk("s6_depth_mid", 32'(depth), 32'd2);
    #1 rst_n = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    chk("s6_rst_ready",  32'(bus.op_ready), 32'd1);
    chk("s6_rst_depth",  32'(depth), 32'd0);
    chk("s6_rst_top",    32'(top), 32'd0);
    chk("s6_rst_second", 32'(second), 32'd0);
    chk("s6_rst_empty",  32'(empty), 32'd1);
    chk("s6_rst_full",   32'(full), 32'd0);
    chk("s6_rst_carry",  32'(carry), 32'd0);
    chk("s6_rst_error",  32'(error), 32'd0);
    chk("s6_rst_out",    32'(out_reg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      rop  = ($urandom_range(0, 9) < 4) ? 4'h1 : 4'($urandom_range(0, 15));
      rval = 4'($urandom_range(0, 15));
      run_op(rop, rval);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
